// File: rtl/pong_match_if.sv
`default_nettype none
// ============================================================================
//  Module   : pong_match_if
//  Purpose  : Signal bundle between the Pong match controller and the rest of
//             the game (paddle/ball controllers, draw and score display).
//  Ports    : frame_tick, start, ball_x, ball_y, p1_paddle_y, p2_paddle_y
//             flow into the controller; state, running, ball_reset,
//             serve_dir, p1_score, p2_score and winner flow out of it.
//             modport slave  - the match controller
//             modport master - whoever drives the game inputs
//  Revision : 1.0  initial release
// ============================================================================
interface pong_match_if #(
    parameter int SCORE_W = 4
);
    logic               frame_tick;
    logic               start;
    logic [5:0]         ball_x;
    logic [5:0]         ball_y;
    logic [5:0]         p1_paddle_y;
    logic [5:0]         p2_paddle_y;
    logic [2:0]         state;
    logic               running;
    logic               ball_reset;
    logic               serve_dir;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [1:0]         winner;

    modport master (
        output frame_tick, start, ball_x, ball_y, p1_paddle_y, p2_paddle_y,
        input  state, running, ball_reset, serve_dir, p1_score, p2_score, winner
    );

    modport slave (
        input  frame_tick, start, ball_x, ball_y, p1_paddle_y, p2_paddle_y,
        output state, running, ball_reset, serve_dir, p1_score, p2_score, winner
    );
endinterface
`default_nettype wire

// File: rtl/pong_match_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pong_match_ctrl
//  Purpose  : Pong match sequencer IDLE/SERVE/RUNNING/POINT/GAME_OVER. Keeps
//             both scores, detects misses against the paddle extents and
//             declares a winner (first-to-N or win-by-two). Timing of the
//             serve delay and point hold is counted in video frames.
//  Ports    : clock      - pixel clock
//             reset_n    - asynchronous active-low reset
//             bus        - pong_match_if.slave (game inputs, state/score outs)
//  Revision : 1.0  initial release
// ============================================================================
module pong_match_ctrl #(
    parameter int GAME_WIDTH    = 40,
    parameter int GAME_HEIGHT   = 30,
    parameter int PADDLE_HEIGHT = 6,
    parameter int SCORE_LIMIT   = 9,
    parameter int SCORE_W       = 4,
    parameter int WIN_BY_TWO    = 0,
    parameter int SERVE_FRAMES  = 60,
    parameter int HOLD_FRAMES   = 30
) (
    input  wire logic   clock,
    input  wire logic   reset_n,
    pong_match_if.slave bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SERVE     = 3'd1;
    localparam logic [2:0] S_RUNNING   = 3'd2;
    localparam logic [2:0] S_POINT     = 3'd3;
    localparam logic [2:0] S_GAME_OVER = 3'd4;

    localparam int CNT_MAX = (SERVE_FRAMES > HOLD_FRAMES) ? SERVE_FRAMES : HOLD_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   C_SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0]   C_HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [SCORE_W:0]   C_LIMIT      = (SCORE_W+1)'(SCORE_LIMIT);
    localparam logic [SCORE_W-1:0] C_LIMIT_M1   = SCORE_W'(SCORE_LIMIT - 1);
    localparam logic [6:0]         C_P2_COL     = 7'(GAME_WIDTH - 1);
    localparam logic [6:0]         C_PAD_SPAN   = 7'(PADDLE_HEIGHT - 1);

    // Parameter sanity: coordinates are 6 bits and scores must hold the limit.
    if (SCORE_LIMIT < 2 || (1 << SCORE_W) <= SCORE_LIMIT || GAME_WIDTH > 64 ||
        GAME_HEIGHT > 64 || SERVE_FRAMES < 1 || HOLD_FRAMES < 1) begin : g_param_error
        $error("pong_match_ctrl: illegal parameter set");
    end

    logic [2:0]         r_state,      w_state_nx;
    logic [CNT_W-1:0]   r_cnt,        w_cnt_nx;
    logic [SCORE_W-1:0] r_p1,         w_p1_nx;
    logic [SCORE_W-1:0] r_p2,         w_p2_nx;
    logic [1:0]         r_winner,     w_winner_nx;
    logic               r_serve_dir,  w_serve_dir_nx;
    logic               r_ball_reset;

    // Miss detection in 7 bits so paddle_y+PADDLE_HEIGHT-1 cannot wrap.
    logic [6:0] w_bx, w_by, w_p1_top, w_p2_top, w_p1_bot, w_p2_bot;
    logic       w_p1_miss, w_p2_miss;

    assign w_bx     = {1'b0, bus.ball_x};
    assign w_by     = {1'b0, bus.ball_y};
    assign w_p1_top = {1'b0, bus.p1_paddle_y};
    assign w_p2_top = {1'b0, bus.p2_paddle_y};
    assign w_p1_bot = w_p1_top + C_PAD_SPAN;
    assign w_p2_bot = w_p2_top + C_PAD_SPAN;

    assign w_p2_miss = (w_bx == C_P2_COL) && ((w_by < w_p2_top) || (w_by > w_p2_bot));
    assign w_p1_miss = (w_bx == 7'd0)     && ((w_by < w_p1_top) || (w_by > w_p1_bot));

    // Post-increment scores, one bit wider so the win compare never wraps.
    logic [SCORE_W:0] w_p1_inc, w_p2_inc;
    logic             w_p1_wins, w_p2_wins, w_p1_deuce, w_p2_deuce;

    assign w_p1_inc = {1'b0, r_p1} + (SCORE_W+1)'(1);
    assign w_p2_inc = {1'b0, r_p2} + (SCORE_W+1)'(1);

    assign w_p1_wins = (WIN_BY_TWO != 0)
                     ? ((w_p1_inc >= C_LIMIT) && (w_p1_inc >= {1'b0, r_p2} + (SCORE_W+1)'(2)))
                     : (w_p1_inc == C_LIMIT);
    assign w_p2_wins = (WIN_BY_TWO != 0)
                     ? ((w_p2_inc >= C_LIMIT) && (w_p2_inc >= {1'b0, r_p1} + (SCORE_W+1)'(2)))
                     : (w_p2_inc == C_LIMIT);

    // Deuce: both at the limit would be reached; pull both back one point so
    // the scores stay bounded however long the rally of points lasts.
    assign w_p1_deuce = (WIN_BY_TWO != 0) && (w_p1_inc == C_LIMIT) && ({1'b0, r_p2} == C_LIMIT);
    assign w_p2_deuce = (WIN_BY_TWO != 0) && (w_p2_inc == C_LIMIT) && ({1'b0, r_p1} == C_LIMIT);

    // State and datapath register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_p1         <= '0;
            r_p2         <= '0;
            r_winner     <= 2'd0;
            r_serve_dir  <= 1'b0;
            r_ball_reset <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_p1         <= w_p1_nx;
            r_p2         <= w_p2_nx;
            r_winner     <= w_winner_nx;
            r_serve_dir  <= w_serve_dir_nx;
            r_ball_reset <= (w_state_nx == S_SERVE) && (r_state != S_SERVE);
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_p1_nx        = r_p1;
        w_p2_nx        = r_p2;
        w_winner_nx    = r_winner;
        w_serve_dir_nx = r_serve_dir;

        case (r_state)
            S_IDLE, S_GAME_OVER: begin
                if (bus.start) begin
                    w_state_nx     = S_SERVE;
                    w_p1_nx        = '0;
                    w_p2_nx        = '0;
                    w_winner_nx    = 2'd0;
                    w_serve_dir_nx = 1'b1;
                end
            end
            S_SERVE: begin
                if (bus.frame_tick) begin
                    if (r_cnt == C_SERVE_LAST) w_state_nx = S_RUNNING;
                    else                       w_cnt_nx   = r_cnt + CNT_W'(1);
                end
            end
            S_RUNNING: begin
                // P2 missing takes priority when both columns coincide.
                if (w_p2_miss) begin
                    w_serve_dir_nx = 1'b1;
                    if (w_p1_wins) begin
                        w_state_nx  = S_GAME_OVER;
                        w_p1_nx     = w_p1_inc[SCORE_W-1:0];
                        w_winner_nx = 2'd1;
                    end else if (w_p1_deuce) begin
                        w_state_nx = S_POINT;
                        w_p1_nx    = C_LIMIT_M1;
                        w_p2_nx    = C_LIMIT_M1;
                    end else begin
                        w_state_nx = S_POINT;
                        w_p1_nx    = w_p1_inc[SCORE_W-1:0];
                    end
                end else if (w_p1_miss) begin
                    w_serve_dir_nx = 1'b0;
                    if (w_p2_wins) begin
                        w_state_nx  = S_GAME_OVER;
                        w_p2_nx     = w_p2_inc[SCORE_W-1:0];
                        w_winner_nx = 2'd2;
                    end else if (w_p2_deuce) begin
                        w_state_nx = S_POINT;
                        w_p1_nx    = C_LIMIT_M1;
                        w_p2_nx    = C_LIMIT_M1;
                    end else begin
                        w_state_nx = S_POINT;
                        w_p2_nx    = w_p2_inc[SCORE_W-1:0];
                    end
                end
            end
            S_POINT: begin
                if (bus.frame_tick) begin
                    if (r_cnt == C_HOLD_LAST) w_state_nx = S_SERVE;
                    else                      w_cnt_nx   = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // Counter restarts on every state change; a tick on that cycle is dropped.
        if (w_state_nx != r_state) w_cnt_nx = '0;
    end

    // Output decode.
    always_comb begin
        bus.state      = r_state;
        bus.running    = (r_state == S_RUNNING);
        bus.ball_reset = r_ball_reset;
        bus.serve_dir  = r_serve_dir;
        bus.p1_score   = r_p1;
        bus.p2_score   = r_p2;
        bus.winner     = r_winner;
    end

endmodule
`default_nettype wire
